neuron_seq_ctrl: RTL and testbench
==================================

Name: neuron_seq_ctrl

Overview:
Sequencer for the 8-input output neuron. Accepts a serial stream of input activations and weights, holds them in parallel registers that drive the neuron's x/w ports, and generates the neuron enable and loss-pass strobes. Counts samples per batch and signals per-sample and per-batch completion. Sits between the upstream activation/weight source and the output neuron.

Parameters:
N_IN, 8, number of neuron inputs (x and w lanes)
X_W, 10, activation width; also the width of the serial data bus
W_W, 8, weight width; taken from data_i[W_W-1:0]
N_SAMPLES, 4, samples per batch; must be at least 1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  pulse; starts a batch; honoured only in IDLE
abort_i  in  1  synchronous abort; returns to IDLE next cycle from any state
data_i  in  X_W  serial word: x0..x(N_IN-1), then w0..w(N_IN-1)
data_valid_i  in  1  data_i valid
data_ready_o  out  1  high only in LOAD; a word transfers when valid and ready are both high
x_bus_o  out  N_IN*X_W  packed x registers; lane k = [k*X_W +: X_W]
w_bus_o  out  N_IN*W_W  packed w registers; lane k = [k*W_W +: W_W]
neuron_en_o  out  1  neuron enable
f0_pass_o  out  1  neuron loss-capture qualifier
busy_o  out  1  high when not in IDLE
sample_done_o  out  1  one-cycle pulse per completed sample
batch_done_o  out  1  one-cycle pulse after the last sample
sample_cnt_o  out  $clog2(N_SAMPLES+1)  samples completed in the current batch

Behaviour:
- Reset: state IDLE; every output low or zero, including x/w registers and sample_cnt_o.
- States: IDLE, LOAD, COMPUTE, LOSS, DONE.
- IDLE:
  - On start_i, go to LOAD.
  - Clear sample_cnt_o and the word index.
- LOAD:
  - data_ready_o=1.
  - Each accepted word is written to lane idx: idx 0..N_IN-1 go to x; idx N_IN..2*N_IN-1 go to w (lower W_W bits).
  - idx increments on acceptance only; cycles with valid low are stalls with no change.
  - When the last word is accepted, clear idx and go to COMPUTE.
- COMPUTE (1 cycle):
  - neuron_en_o=1, f0_pass_o=0; the neuron registers its weighted sum.
  - Next state LOSS.
- LOSS (1 cycle):
  - neuron_en_o=1, f0_pass_o=1; the neuron captures loss from the sum registered in COMPUTE.
  - Inputs are unchanged, so re-registering the sum is idempotent.
  - Next state DONE.
- DONE (1 cycle):
  - sample_done_o=1 and sample_cnt_o increments.
  - If the new count equals N_SAMPLES: batch_done_o=1 in this same cycle, then go to IDLE. Otherwise go to LOAD.
- Latency: from acceptance of the last word, neuron_en_o is high 1 and 2 cycles later, and sample_done_o is high 3 cycles later.
- x/w registers hold their values after each sample and in IDLE; they change only on accepted writes.
- abort_i has priority over every transition:
  - Next state is IDLE and idx is cleared.
  - No strobes are generated in the cycle after abort.
  - x/w registers and sample_cnt_o are retained until the next start_i.
- start_i outside IDLE is ignored.
- Simultaneous start_i and abort_i in IDLE: abort wins and the block stays in IDLE.
- Asynchronous reset mid-operation: immediate return to the reset state; any partial load is discarded.

Optional Feature:
NEURON_SEQ_WEIGHT_HOLD_EN
- Defined:
  - Weights load only for the first sample of a batch.
  - Later samples load N_IN words (x only), then go straight to COMPUTE; w registers are unchanged.
  - An abort forces a full 2*N_IN-word load on the next batch.
- Undefined: every sample loads all 2*N_IN words.

Test Plan:
- Reset held, then released -> all outputs 0, busy_o=0, data_ready_o=0.
- start_i, stream x=1..8 and w=0x10..0x17 with valid always high -> x lane3=4, w lane7=0x17; neuron_en_o high on cycles +1 and +2 after the 16th word; f0_pass_o high only on +2; sample_done_o on +3; sample_cnt_o=1.
- Same load with valid low on alternate cycles -> identical lane contents; LOAD lasts 32 cycles; no extra acceptances.
- N_SAMPLES=4, four full samples -> four sample_done_o pulses; batch_done_o coincides with the 4th; then IDLE, busy_o=0.
- abort_i after 5 words -> IDLE next cycle, no neuron_en_o; a new start_i then requires 16 words (or 16 for the first sample with WEIGHT_HOLD_EN defined).
- NEURON_SEQ_WEIGHT_HOLD_EN defined, 2 samples -> the second sample accepts exactly 8 words and w lanes keep their first-sample values.

Source files
------------

// File: rtl/neuron_seq_ctrl.sv
// Sequencer for the 8-input output neuron: serial x/w loading, enable/loss strobes, sample and batch counting.
// Optional feature macro: NEURON_SEQ_WEIGHT_HOLD_EN (weights are loaded only for the first sample of a batch).
module neuron_seq_ctrl #(
  parameter int N_IN      = 8,
  parameter int X_W       = 10,
  parameter int W_W       = 8,
  parameter int N_SAMPLES = 4,
  localparam int CNT_W    = $clog2(N_SAMPLES + 1),
  localparam int IDX_W    = $clog2(2 * N_IN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [X_W-1:0]        data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [N_IN*X_W-1:0]   x_bus_o,
  output logic [N_IN*W_W-1:0]   w_bus_o,
  output logic                  neuron_en_o,
  output logic                  f0_pass_o,
  output logic                  busy_o,
  output logic                  sample_done_o,
  output logic                  batch_done_o,
  output logic [CNT_W-1:0]      sample_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    LOSS    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic             accept;
  logic             last_word;
  logic             hold_w;

  assign accept    = (state == LOAD) && data_valid_i;
  assign last_idx  = hold_w ? IDX_W'(N_IN - 1) : IDX_W'(2 * N_IN - 1);
  assign last_word = (idx == last_idx);

`ifdef NEURON_SEQ_WEIGHT_HOLD_EN
  logic w_loaded;

  // Remembers that this batch already has its weights; cleared by abort or a new batch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_loaded <= 1'b0;
    end else if (abort_i || ((state == IDLE) && start_i)) begin
      w_loaded <= 1'b0;
    end else if (accept && last_word) begin
      w_loaded <= 1'b1;
    end
  end

  assign hold_w = w_loaded;
`else
  assign hold_w = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_i) next_state = LOAD; else next_state = IDLE;
      LOAD:    if (accept && last_word) next_state = COMPUTE; else next_state = LOAD;
      COMPUTE: next_state = LOSS;
      LOSS:    next_state = DONE;
      DONE:    if (sample_cnt_o == CNT_W'(N_SAMPLES)) next_state = IDLE; else next_state = LOAD;
      default: next_state = IDLE;
    endcase
    if (abort_i) begin
      next_state = IDLE;
    end else begin
      next_state = next_state;
    end
  end

  // Word index, lane registers and sample counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx          <= {IDX_W{1'b0}};
      x_bus_o      <= {(N_IN*X_W){1'b0}};
      w_bus_o      <= {(N_IN*W_W){1'b0}};
      sample_cnt_o <= {CNT_W{1'b0}};
    end else begin
      if (abort_i || (state == IDLE)) begin
        idx <= {IDX_W{1'b0}};
      end else if (accept) begin
        idx <= last_word ? {IDX_W{1'b0}} : idx + IDX_W'(1);
      end
      for (int k = 0; k < N_IN; k++) begin
        if (accept && (idx == IDX_W'(k))) begin
          x_bus_o[k*X_W +: X_W] <= data_i;
        end
        if (accept && (idx == IDX_W'(N_IN + k))) begin
          w_bus_o[k*W_W +: W_W] <= data_i[W_W-1:0];
        end
      end
      // Count survives abort and batch end; only an honoured start clears it.
      if ((state == IDLE) && start_i && !abort_i) begin
        sample_cnt_o <= {CNT_W{1'b0}};
      end else if ((state == LOSS) && !abort_i) begin
        sample_cnt_o <= sample_cnt_o + CNT_W'(1);
      end
    end
  end

  // Strobes registered from the next state so they align with the state they decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_ready_o  <= 1'b0;
      neuron_en_o   <= 1'b0;
      f0_pass_o     <= 1'b0;
      busy_o        <= 1'b0;
      sample_done_o <= 1'b0;
      batch_done_o  <= 1'b0;
    end else begin
      data_ready_o  <= (next_state == LOAD);
      neuron_en_o   <= (next_state == COMPUTE) || (next_state == LOSS);
      f0_pass_o     <= (next_state == LOSS);
      busy_o        <= (next_state != IDLE);
      sample_done_o <= (next_state == DONE);
      batch_done_o  <= (next_state == DONE) &&
                       ((sample_cnt_o + CNT_W'(1)) == CNT_W'(N_SAMPLES));
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboard bench for neuron_seq_ctrl: randomized loads checked against a lane/sample model.
module tb_neuron_seq_ctrl;
  localparam int N_IN      = 8;
  localparam int X_W       = 10;
  localparam int W_W       = 8;
  localparam int N_SAMPLES = 4;
  localparam int CNT_W     = $clog2(N_SAMPLES + 1);
`ifdef NEURON_SEQ_WEIGHT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                start_i = 1'b0;
  logic                abort_i = 1'b0;
  logic [X_W-1:0]      data_i = '0;
  logic                data_valid_i = 1'b0;
  logic                data_ready_o;
  logic [N_IN*X_W-1:0] x_bus_o;
  logic [N_IN*W_W-1:0] w_bus_o;
  logic                neuron_en_o, f0_pass_o, busy_o, sample_done_o, batch_done_o;
  logic [CNT_W-1:0]    sample_cnt_o;

  neuron_seq_ctrl #(.N_IN(N_IN), .X_W(X_W), .W_W(W_W), .N_SAMPLES(N_SAMPLES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .x_bus_o(x_bus_o), .w_bus_o(w_bus_o), .neuron_en_o(neuron_en_o),
    .f0_pass_o(f0_pass_o), .busy_o(busy_o), .sample_done_o(sample_done_o),
    .batch_done_o(batch_done_o), .sample_cnt_o(sample_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N_IN*X_W-1:0] x;
    logic [N_IN*W_W-1:0] w;
    int                  cnt;
    bit                  batch;
    int                  cyc;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             samples_m = 0;
  logic [X_W-1:0] x_m [N_IN];
  logic [W_W-1:0] w_m [N_IN];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [N_IN*X_W-1:0] pack_x();
    logic [N_IN*X_W-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*X_W +: X_W] = x_m[k];
    return r;
  endfunction

  function automatic logic [N_IN*W_W-1:0] pack_w();
    logic [N_IN*W_W-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*W_W +: W_W] = w_m[k];
    return r;
  endfunction

  function automatic int words_for(input int s);
    return (HOLD && (s > 0)) ? N_IN : 2 * N_IN;
  endfunction

  // Monitor: pops the scoreboard on every sample_done_o and checks strobe history.
  logic en_h1 = 1'b0, en_h2 = 1'b0, f0_h1 = 1'b0, f0_h2 = 1'b0;
  always @(negedge clk_i) begin
    exp_t e;
    chk("batch_without_sample", 128'(batch_done_o & ~sample_done_o), 128'(0));
    chk("ready_en_exclusive", 128'(data_ready_o & neuron_en_o), 128'(0));
    if (sample_done_o) begin
      chk("sb_has_entry", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_latency", 128'(cyc), 128'(e.cyc));
        chk("x_bus", 128'(x_bus_o), 128'(e.x));
        chk("w_bus", 128'(w_bus_o), 128'(e.w));
        chk("sample_cnt", 128'(sample_cnt_o), 128'(e.cnt));
        chk("batch_done", 128'(batch_done_o), 128'(e.batch));
        chk("en_history", 128'({en_h2, en_h1, neuron_en_o}), 128'(3'b110));
        chk("f0_history", 128'({f0_h2, f0_h1, f0_pass_o}), 128'(3'b010));
      end
    end
    en_h2 <= en_h1;
    en_h1 <= neuron_en_o;
    f0_h2 <= f0_h1;
    f0_h1 <= f0_pass_o;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_ready"}, 128'(data_ready_o), 128'(0));
    chk({tag, "_en"}, 128'({neuron_en_o, f0_pass_o, sample_done_o, batch_done_o}), 128'(0));
    chk({tag, "_cnt"}, 128'(sample_cnt_o), 128'(0));
    chk({tag, "_x"}, 128'(x_bus_o), 128'(0));
    chk({tag, "_w"}, 128'(w_bus_o), 128'(0));
  endtask

  task automatic clear_model();
    for (int k = 0; k < N_IN; k++) begin
      x_m[k] = '0;
      w_m[k] = '0;
    end
    samples_m = 0;
  endtask

  task automatic start_batch();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    samples_m = 0;
  endtask

  // Loads one sample (mode 0: valid always, 1: valid on odd cycles, 2: random);
  // stop_after > 0 sends only that many words and expects no completion.
  task automatic load_sample(input int mode, input bit directed, input int stop_after);
    int n, sent, k, guard, last_c;
    bit v;
    logic [X_W-1:0] d;
    n = (stop_after > 0) ? stop_after : words_for(samples_m);
    sent = 0; k = 0; guard = 0; last_c = 0;
    while (!data_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    chk("ready_at_load_start", 128'(data_ready_o), 128'(1));
    while (sent < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = k[0];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      chk("ready_in_load", 128'(data_ready_o), 128'(1));
      start_i = (mode == 2) && ($urandom_range(0, 4) == 0);
      if (v) begin
        if (directed) d = (sent < N_IN) ? X_W'(sent + 1) : X_W'(16 + sent - N_IN);
        else d = X_W'($urandom);
        if (sent < N_IN) x_m[sent] = d;
        else w_m[sent - N_IN] = d[W_W-1:0];
        sent++;
        last_c = cyc;
      end else begin
        d = X_W'($urandom);
      end
      data_i = d;
      data_valid_i = v;
      k++;
      @(negedge clk_i);
    end
    data_valid_i = 1'b0;
    start_i = 1'b0;
    if (stop_after == 0) begin
      chk("ready_after_last_word", 128'(data_ready_o), 128'(0));
      samples_m++;
      sb.push_back('{pack_x(), pack_w(), samples_m, (samples_m == N_SAMPLES), last_c + 3});
    end
  endtask

  task automatic wait_idle_after_batch();
    int g = 0;
    while (busy_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    chk("batch_end_busy", 128'(busy_o), 128'(0));
    chk("batch_end_cnt", 128'(sample_cnt_o), 128'(N_SAMPLES));
    chk("batch_end_sb_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic run_batch(input bit directed);
    start_batch();
    for (int s = 0; s < N_SAMPLES; s++) begin
      load_sample((s == 0) ? 0 : ((s == 1) ? 1 : 2), directed && (s < 2), 0);
    end
    wait_idle_after_batch();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    clear_model();
    repeat (3) @(negedge clk_i);
    check_zero("in_reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_zero("after_reset");

    // Directed first sample (x=1..8, w=0x10..0x17), alternate-valid second, then random.
    run_batch(1'b1);
    for (int b = 0; b < 2; b++) run_batch(1'b0);

    // Abort partway through the second sample of a batch.
    start_batch();
    load_sample(0, 1'b0, 0);
    load_sample(0, 1'b0, 5);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_busy", 128'(busy_o), 128'(0));
      chk("abort_strobes", 128'({data_ready_o, neuron_en_o, f0_pass_o, sample_done_o}), 128'(0));
      chk("abort_x_kept", 128'(x_bus_o), 128'(pack_x()));
      chk("abort_w_kept", 128'(w_bus_o), 128'(pack_w()));
      chk("abort_cnt_kept", 128'(sample_cnt_o), 128'(1));
      @(negedge clk_i);
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk("start_abort_idle", 128'(busy_o), 128'(0));
    chk("start_abort_cnt", 128'(sample_cnt_o), 128'(1));
    run_batch(1'b0);

    // Asynchronous reset in the middle of a load.
    start_batch();
    load_sample(0, 1'b0, 3);
    rst_i = 1'b1;
    #1;
    clear_model();
    check_zero("mid_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    run_batch(1'b0);

    repeat (4) @(negedge clk_i);
    chk("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
